// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op codes,
// state encoding and the default operand width.
package hilo_muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;

endpackage

// File: rtl/hilo_muldiv_unit_iter_step.sv
// One iteration of the shared datapath: shift-add for multiply, restoring
// compare-subtract-shift for divide. Purely combinational.
module muldiv_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic                 is_div,
    input  logic [2*WIDTH-1:0]   acc,
    input  logic [WIDTH-1:0]     opnd,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend shifting into quotient}.
    always_comb begin
        sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
        rem_sh = acc[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh[WIDTH-1:0] - opnd;
        if (is_div) begin
            if (rem_sh >= {1'b0, opnd}) begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; also takes
// MTHI/MTLO writes. Handshake: start is accepted only while busy=0 (and abort=0);
// done pulses for one cycle when a multiply/divide commits to HI/LO.
module hilo_muldiv_unit
    import hilo_muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
    logic                 busy_q, busy_d, done_q, done_d, dz_q, dz_d;
    logic                 is_div_q, is_div_d, neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d, dz_pend_q, dz_pend_d;

    logic                 signed_op, div_op;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   step_next;

    muldiv_iter_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .opnd     (opnd_q),
        .acc_next (step_next)
    );

    always_comb begin
        signed_op = (op == OP_MULT) || (op == OP_DIV);
        div_op    = (op == OP_DIV) || (op == OP_DIVU);
        // The most negative value negates to itself and is then read as unsigned.
        mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
        mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;

        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_pend_d = dz_pend_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    case (op)
                        OP_MTHI: begin
                            hi_d = a;
                            dz_d = 1'b0;
                        end
                        OP_MTLO: begin
                            lo_d = a;
                            dz_d = 1'b0;
                        end
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = div_op;
                            neg_res_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = signed_op && a[WIDTH-1];
                            cnt_d     = '0;
                            dz_d      = 1'b0;
                            busy_d    = 1'b1;
                            opnd_d    = mag_b;
                            if (div_op && (b == '0)) begin
                                dz_pend_d = 1'b1;
                                acc_d     = {{WIDTH{1'b0}}, a};
                                state_d   = ST_FIXUP;
                            end else begin
                                dz_pend_d = 1'b0;
                                acc_d     = {{WIDTH{1'b0}}, mag_a};
                                state_d   = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = step_next;
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = ST_FIXUP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_FIXUP: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (!abort) begin
                    done_d = 1'b1;
                    if (dz_pend_q) begin
                        hi_d = acc_q[WIDTH-1:0];
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else if (is_div_q) begin
                        lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        {hi_d, lo_d} = neg_res_q ? -acc_q : acc_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_pend_q <= dz_pend_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Bench for hilo_muldiv_unit: an arithmetic/latency model checked every cycle,
// plus directed vectors with hand-computed HI/LO values.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2;
    localparam logic [2:0] T_DIVU = 3'd3, T_MTHI = 3'd4, T_MTLO = 3'd5;

    logic        clk, rst_n, start, abort;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        busy, done, div_zero;
    logic [31:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    hilo_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .abort(abort), .busy(busy), .done(done), .div_zero(div_zero),
        .hi(hi), .lo(lo)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = 0, m_lo = 0, p_hi = 0, p_lo = 0;
    logic        m_done = 0, m_dz = 0, p_dz = 0;
    int          remain = 0;

    always @(posedge clk or negedge rst_n) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, uq, ur, prod;
        if (!rst_n) begin
            m_hi = 0; m_lo = 0; m_done = 0; m_dz = 0; remain = 0;
        end else begin
            m_done = 0;
            if (remain > 0) begin
                if (abort) remain = 0;
                else begin
                    remain = remain - 1;
                    if (remain == 0) begin
                        m_hi = p_hi; m_lo = p_lo; m_dz = p_dz; m_done = 1;
                    end
                end
            end else if (start && !abort) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                ua = {32'b0, a};           ub = {32'b0, b};
                p_dz = 0;
                case (op)
                    T_MTHI: begin m_hi = a; m_dz = 0; end
                    T_MTLO: begin m_lo = a; m_dz = 0; end
                    T_MULT: begin
                        prod = longint'(sa * sb);
                        p_hi = prod[63:32]; p_lo = prod[31:0];
                        remain = 33; m_dz = 0;
                    end
                    T_MULTU: begin
                        prod = ua * ub;
                        p_hi = prod[63:32]; p_lo = prod[31:0];
                        remain = 33; m_dz = 0;
                    end
                    T_DIV, T_DIVU: begin
                        m_dz = 0;
                        if (b == 0) begin
                            p_hi = a; p_lo = 32'hFFFF_FFFF; p_dz = 1; remain = 1;
                        end else begin
                            if (op == T_DIV) begin
                                sq = sa / sb; sr = sa % sb;
                                p_lo = sq[31:0]; p_hi = sr[31:0];
                            end else begin
                                uq = ua / ub; ur = ua % ub;
                                p_lo = uq[31:0]; p_hi = ur[31:0];
                            end
                            remain = 33;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_busy", {31'b0, busy}, {31'b0, (remain > 0)});
            chk("model_done", {31'b0, done}, {31'b0, m_done});
            chk("model_dz",   {31'b0, div_zero}, {31'b0, m_dz});
            chk("model_hi",   hi, m_hi);
            chk("model_lo",   lo, m_lo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        start = 1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el);
        issue(o, x, y);
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk); #1;
            if (i == 1 || i == 32) chk({nm, "_busy"}, {31'b0, busy}, 32'd1);
        end
        @(posedge clk); #1;
        chk({nm, "_done"}, {31'b0, done}, 32'd1);
        chk({nm, "_busy_off"}, {31'b0, busy}, 32'd0);
        chk({nm, "_hi"}, hi, eh);
        chk({nm, "_lo"}, lo, el);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n = 1; start = 0; abort = 0; op = 0; a = 0; b = 0;
        #3 rst_n = 0;
        #1 chk_en = 1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz", {31'b0, div_zero}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;

        run_op("multu_ff", T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        @(posedge clk); #1;
        chk("done_pulse_once", {31'b0, done}, 32'd0);
        run_op("mult_neg", T_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_op("div_neg", T_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu", T_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_ovf", T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
        chk("div_ovf_dz", {31'b0, div_zero}, 32'd0);

        // Divide by zero: commit one edge after accept.
        issue(T_DIVU, 32'h1234, 32'h0);
        chk("dz_busy", {31'b0, busy}, 32'd1);
        @(posedge clk); #1;
        chk("dz_done", {31'b0, done}, 32'd1);
        chk("dz_hi", hi, 32'h1234);
        chk("dz_lo", lo, 32'hFFFF_FFFF);
        chk("dz_flag", {31'b0, div_zero}, 32'd1);

        issue(T_MTLO, 32'hA5A5_A5A5, 32'h0);
        chk("mtlo_lo", lo, 32'hA5A5_A5A5);
        chk("mtlo_hi", hi, 32'h1234);
        chk("mtlo_dz", {31'b0, div_zero}, 32'd0);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);

        // Reserved op codes do nothing.
        issue(3'd7, 32'h5555_5555, 32'h1);
        chk("rsv_busy", {31'b0, busy}, 32'd0);
        chk("rsv_lo", lo, 32'hA5A5_A5A5);

        // Abort together with start in idle: start dropped.
        abort = 1;
        issue(T_MULTU, 32'd3, 32'd3);
        abort = 0;
        chk("abort_idle_busy", {31'b0, busy}, 32'd0);

        // Abort mid-run, with an ignored start in between.
        issue(T_MULTU, 32'd7, 32'd6);
        repeat (4) @(posedge clk); #1;
        issue(T_MULT, 32'd1, 32'd1);
        chk("ign_start_busy", {31'b0, busy}, 32'd1);
        repeat (4) @(posedge clk); #1;
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_hi", hi, 32'h1234);
        chk("abort_lo", lo, 32'hA5A5_A5A5);
        repeat (30) @(posedge clk); #1;
        chk("abort_hi_late", hi, 32'h1234);

        run_op("multu_7x6", T_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);

        // Asynchronous reset in the middle of a run.
        issue(T_MULTU, 32'h10, 32'h20);
        repeat (19) @(posedge clk); #1;
        rst_n = 0;
        #1;
        chk("mid_rst_hi", hi, 32'h0);
        chk("mid_rst_lo", lo, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'd0);
        chk("mid_rst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        issue(T_MTHI, 32'hDEAD_BEEF, 32'h0);
        chk("mthi_hi", hi, 32'hDEAD_BEEF);
        chk("mthi_lo", lo, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        n_err++;
        $display("FAIL timeout: simulation did not complete, got no end expected end");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
